// File: rtl/io_sw_pkg.sv
// Shared defaults, register map and word-extension helper for the switch-capture peripheral.
`timescale 1ns/1ps
package io_sw_pkg;

    localparam int DEF_SW_W       = 17;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_STROBE_BIT = 16;
    localparam int DEF_DEPTH      = 4;

    // Byte offsets inside the LSU I/O window.
    typedef enum logic [3:0] {
        SW_DATA_OFF   = 4'h0,
        SW_STATUS_OFF = 4'h4,
        SW_LIVE_OFF   = 4'h8
    } sw_reg_e;

    function automatic logic [31:0] sw_extend(input logic [31:0] data,
                                              input int unsigned width = DEF_DATA_W,
                                              input logic signed_sel = 1'b1);
        logic [31:0] mask;
        logic [31:0] word;
        mask = 32'hFFFF_FFFF >> (32 - width);
        word = data & mask;
        if (signed_sel && data[width-1]) begin
            word = word | ~mask;
        end
        return word;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Multi-flop synchroniser followed by a whole-vector debounce filter.
`timescale 1ns/1ps
module sw_debounce #(
    parameter int W            = 17,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] stable_o
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]                  sample_q, sample_d;
    logic [W-1:0]                  stable_q, stable_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        sync_d   = {sync_q[SYNC_STAGES-2:0], async_i};
        sample_d = sample_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q[SYNC_STAGES-1] != sample_q) begin
            sample_d = sync_q[SYNC_STAGES-1];
            cnt_d    = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sample_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            sample_q <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            sample_q <= sample_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/io_sw_capture.sv
// Debounced switch capture: an enter-strobe rising edge pushes the extended data field into a FIFO.
// Optional SW_IRQ_EN adds a registered, maskable interrupt on FIFO non-empty or overflow.
`timescale 1ns/1ps
module io_sw_capture
    import io_sw_pkg::*;
#(
    parameter int SW_W         = DEF_SW_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STROBE_BIT   = DEF_STROBE_BIT,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int SIGNED       = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [SW_W-1:0]        io_sw_i,
    input  logic                   rd_i,
    input  logic                   clr_i,
    input  logic                   irq_mask_i,
    output logic [31:0]            data_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic [SW_W-1:0]        live_o,
    output logic                   irq_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [SW_W-1:0]   stable;
    logic              strobe_prev_q, strobe_prev_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push, pop, full, wr_en;

    sw_debounce #(
        .W            (SW_W),
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .async_i  (io_sw_i),
        .stable_o (stable)
    );

    always_comb begin
        push          = stable[STROBE_BIT] & ~strobe_prev_q;
        pop           = rd_i && (count_q != '0);
        full          = (count_q == CNT_W'(DEPTH));
        // A full FIFO still accepts a push when the same cycle frees a slot.
        wr_en         = push && (!full || pop);
        strobe_prev_d = stable[STROBE_BIT];
        wr_ptr_d      = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d       = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        overflow_d    = overflow_q;
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end else if (clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            strobe_prev_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            strobe_prev_q <= strobe_prev_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/valid gate every read, so stale words never leak.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= stable[DATA_W-1:0];
        end
    end

    assign valid_o    = (count_q != '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign live_o     = stable;
    assign data_o     = valid_o ? sw_extend(32'(mem_q[rd_ptr_q]), DATA_W, SIGNED != 0) : 32'h0;

`ifdef SW_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_mask_i & (valid_o | overflow_o);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_mask;
    assign unused_irq_mask = irq_mask_i;
    assign irq_o           = 1'b0;
`endif

endmodule

// File: doc/io_sw_capture.md
Name: io_sw_capture

Overview:
Parametrised switch-input peripheral that replaces the raw io_sw_i path into the singlecycle processor's LSU I/O region. It does the following:
- synchronises and debounces the switch bus;
- detects a rising edge on a designated "enter" strobe switch;
- on that edge, pushes the data field into a small FIFO as a signed or unsigned 32-bit word.
Software therefore reads complete entered values (e.g. coordinate pairs) without polling for bounce or missing entries.

Parameters:
- SW_W, 17, total switch bus width.
- DATA_W, 16, width of the data field, taken from io_sw_i[DATA_W-1:0]; DATA_W < SW_W.
- STROBE_BIT, 16, index of the enter switch; STROBE_BIT >= DATA_W.
- SYNC_STAGES, 2, synchroniser flop count; must be >= 2.
- DEBOUNCE_CYC, 4, consecutive stable cycles required; must be >= 1.
- DEPTH, 4, FIFO entries; must be a power of 2 and >= 2.
- SIGNED, 1, 1 = sign-extend the data field to 32 bits, 0 = zero-extend.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- io_sw_i  in  SW_W  raw switch inputs, asynchronous to clk_i.
- rd_i  in  1  pop request, one per cycle, from the LSU read decode.
- clr_i  in  1  synchronous clear of overflow_o.
- irq_mask_i  in  1  interrupt enable; used only with SW_IRQ_EN.
- data_o  out  32  FIFO head word after extension; 0 when empty.
- valid_o  out  1  FIFO non-empty.
- count_o  out  $clog2(DEPTH)+1  number of FIFO entries.
- overflow_o  out  1  sticky flag: a push was dropped because the FIFO was full.
- live_o  out  SW_W  current debounced switch vector.
- irq_o  out  1  interrupt request.

Behaviour:
- Reset (rst_ni low, asynchronous): all synchroniser flops, debounce counter, stable vector, FIFO pointers and overflow cleared. All outputs read 0.
- Synchroniser: SYNC_STAGES flops per bit. Output is sync_q.
- Debounce, whole-vector:
  - sample_q holds the last synchronised value; cnt counts stable cycles.
  - If sync_q != sample_q: sample_q <= sync_q, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYC-1: stable_q <= sample_q, and cnt holds.
  - Else: cnt increments.
  - live_o = stable_q.
  - Latency: a change on io_sw_i held steady appears on live_o exactly SYNC_STAGES+DEBOUNCE_CYC+1 rising edges later.
  - Any input change inside the window restarts the count.
- Strobe edge:
  - push = stable_q[STROBE_BIT] & ~stable_prev_q[STROBE_BIT], where stable_prev_q is stable_q delayed one cycle.
  - Pushed word is the extension of stable_q[DATA_W-1:0].
  - Holding the strobe high pushes once only. The strobe must go low and high again to push again.
  - Data bits changing while the strobe is high cause no push.
- FIFO:
  - Pushed data is visible on data_o/valid_o on the cycle after push.
  - Pop occurs when rd_i && valid_o; the next entry is presented the following cycle. rd_i while empty is ignored.
  - Push while full and no pop: the word is dropped, and overflow_o is set the next cycle.
  - Push and pop together while full: both occur, count is unchanged, no overflow.
  - Push and pop together while empty: push occurs, pop is ignored.
  - Pointers wrap modulo DEPTH. count_o ranges 0..DEPTH.
  - overflow_o clears on clr_i. If clr_i and an overflowing push coincide, set wins.
- Mid-operation reset discards FIFO contents and in-flight debounce state immediately.

Optional Feature:
Macro SW_IRQ_EN.
- Defined: irq_o is registered and equals irq_mask_i & (valid_o | overflow_o) from the previous cycle. It rises one cycle after valid_o rises, given the mask is set.
- Undefined: irq_o is tied 0, and irq_mask_i is ignored. No irq logic is synthesised.

Decomposition:
- Package io_sw_pkg holds:
  - localparam defaults: SW_W, DATA_W, STROBE_BIT, DEPTH;
  - function sw_extend(data, signed_sel) returning a 32-bit word;
  - LSU address offsets for the data, status (valid/count/overflow) and live registers.
- One sub-module, sw_debounce, contains the synchroniser and debounce logic, parametrised by width, SYNC_STAGES and DEBOUNCE_CYC.
- FIFO and edge detect stay inline in io_sw_capture.

Test Plan:
- Basic entry, SIGNED=1: hold io_sw_i=0x0005D for 10 cycles, drive 0x1005D, then 0x0005D → one push; data_o=0x0000005D, valid_o=1, count_o=1.
- Negative value: strobe with io_sw_i=0x1FEA6 → data_o=0xFFFFFEA6 (-346). Rerun with SIGNED=0 → data_o=0x0000FEA6.
- Bounce rejection: toggle bit 16 every 2 cycles for 20 cycles, DEBOUNCE_CYC=4 → live_o[16] never changes, count_o stays 0. Then hold high → exactly one push, SYNC_STAGES+DEBOUNCE_CYC+2 edges after the hold starts.
- Ordering and overflow: 5 strobes with values 93, -346, -88, -493, 26, no reads, DEPTH=4 → count_o=4, overflow_o=1. Four pops yield 0x5D, 0xFFFFFEA6, 0xFFFFFFA8, 0xFFFFFE13 in order. Then valid_o=0 and data_o=0. clr_i → overflow_o=0.
- Simultaneous push and pop at full: rd_i asserted on the push cycle with count_o=4 → count_o stays 4, overflow_o stays 0, new word is last.
- Reset mid-operation: rst_ni low for 1 ns with count_o=3 → all outputs 0 immediately. With SW_IRQ_EN and irq_mask_i=1 → irq_o=1 one cycle after the first subsequent push.
